// File: rtl/dcache_miss_unit.sv
// rtl/dcache_miss_unit.sv - D$ miss handler: optional dirty-victim writeback, then line fill
`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 512
`endif

module dcache_miss_unit #(
  parameter int LINE_W = `DCACHE_LINE_WIDTH,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     miss_valid,
  input  logic [ADDR_W-1:0]        miss_addr,
  input  logic                     evict_dirty,
  input  logic [ADDR_W-1:0]        evict_addr,
  input  logic [LINE_W-1:0]        evict_data,
  output logic                     miss_ready,
  output logic                     dcache_req_valid_miss,
  // memory_request_t packed as {addr, is_store, data}
  output logic [ADDR_W+LINE_W:0]   dcache_req_info_miss,
  input  logic                     rsp_valid_miss,
  input  logic                     rsp_cache_id,
  input  logic [LINE_W-1:0]        rsp_data_miss,
  output logic                     fill_valid,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [LINE_W-1:0]        fill_data,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic [CNT_W-1:0]         wb_cnt
);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       miss_addr_q, miss_addr_d;
  logic [ADDR_W+LINE_W:0]  info_q, info_d;
  logic [ADDR_W-1:0]       fill_addr_q, fill_addr_d;
  logic [LINE_W-1:0]       fill_data_q, fill_data_d;
  logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]        wb_cnt_q, wb_cnt_d;
  logic                    d_rsp;

  // I$ responses share the return path and are never ours
  assign d_rsp = rsp_valid_miss & rsp_cache_id;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (miss_valid) state_d = evict_dirty ? WB_REQ : FILL_REQ;
      WB_REQ:    state_d = WB_WAIT;
      WB_WAIT:   if (d_rsp) state_d = FILL_REQ;
      FILL_REQ:  state_d = FILL_WAIT;
      FILL_WAIT: if (d_rsp) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_ready            = (state_q == IDLE);
    dcache_req_valid_miss = (state_q == WB_REQ) || (state_q == FILL_REQ);
    fill_valid            = (state_q == DONE);
  end

  // Request info is loaded on the edge entering each request state, so it is
  // already stable when the valid pulse appears and holds afterwards.
  always_comb begin
    miss_addr_d = miss_addr_q;
    info_d      = info_q;
    fill_addr_d = fill_addr_q;
    fill_data_d = fill_data_q;
    miss_cnt_d  = miss_cnt_q;
    wb_cnt_d    = wb_cnt_q;
    if (state_q == IDLE && miss_valid) begin
      miss_addr_d = miss_addr;
      info_d      = evict_dirty ? {evict_addr, 1'b1, evict_data}
                                : {miss_addr, 1'b0, {LINE_W{1'b0}}};
    end
    if (state_q == WB_WAIT && d_rsp) begin
      info_d = {miss_addr_q, 1'b0, {LINE_W{1'b0}}};
      if (wb_cnt_q != CNT_MAX) wb_cnt_d = wb_cnt_q + CNT_ONE;
    end
    if (state_q == FILL_WAIT && d_rsp) begin
      fill_addr_d = miss_addr_q;
      fill_data_d = rsp_data_miss;
    end
    if (state_q == DONE && miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      miss_addr_q <= '0;
      info_q      <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
    end else begin
      miss_addr_q <= miss_addr_d;
      info_q      <= info_d;
      fill_addr_q <= fill_addr_d;
      fill_data_q <= fill_data_d;
      miss_cnt_q  <= miss_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
    end
  end

  assign dcache_req_info_miss = info_q;
  assign fill_addr            = fill_addr_q;
  assign fill_data            = fill_data_q;
  assign miss_cnt             = miss_cnt_q;
  assign wb_cnt               = wb_cnt_q;

endmodule

// File: tb/tb_dcache_miss_unit.sv
// tb/tb_dcache_miss_unit.sv - directed bench with a transaction-level scoreboard for dcache_miss_unit
module tb_dcache_miss_unit;
  localparam int LW   = 64;
  localparam int AW   = 32;
  localparam int CW   = 2;
  localparam int RW   = AW + LW + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           miss_valid = 1'b0;
  logic [AW-1:0]  miss_addr = '0;
  logic           evict_dirty = 1'b0;
  logic [AW-1:0]  evict_addr = '0;
  logic [LW-1:0]  evict_data = '0;
  logic           miss_ready;
  logic           dcache_req_valid_miss;
  logic [RW-1:0]  dcache_req_info_miss;
  logic           rsp_valid_miss = 1'b0;
  logic           rsp_cache_id = 1'b0;
  logic [LW-1:0]  rsp_data_miss = '0;
  logic           fill_valid;
  logic [AW-1:0]  fill_addr;
  logic [LW-1:0]  fill_data;
  logic [CW-1:0]  miss_cnt;
  logic [CW-1:0]  wb_cnt;

  dcache_miss_unit #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .evict_dirty(evict_dirty),
    .evict_addr(evict_addr), .evict_data(evict_data), .miss_ready(miss_ready),
    .dcache_req_valid_miss(dcache_req_valid_miss), .dcache_req_info_miss(dcache_req_info_miss),
    .rsp_valid_miss(rsp_valid_miss), .rsp_cache_id(rsp_cache_id), .rsp_data_miss(rsp_data_miss),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: requests and fills the transactions in flight must produce, in order
  logic [RW-1:0]    exp_req_q[$];
  logic [AW+LW-1:0] exp_fill_q[$];
  logic [RW-1:0]    last_req;
  logic [AW+LW-1:0] last_fill;
  int               m_miss, m_wb;
  bit               prev_store;

  // Held-request fields presented once the current miss is accepted
  logic [AW-1:0] nxt_addr;
  logic          nxt_dirty;
  logic [AW-1:0] nxt_eaddr;
  logic [LW-1:0] nxt_edata;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always begin
    logic [RW-1:0]    er;
    logic [AW+LW-1:0] ef;
    @(negedge clock);
    #2;
    if (reset) begin
      last_req = '0; last_fill = '0; m_miss = 0; m_wb = 0; prev_store = 0;
    end else begin
      if (dcache_req_valid_miss) begin
        if (exp_req_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL req_unexpected: got %h want no request", dcache_req_info_miss);
        end else begin
          er = exp_req_q.pop_front();
          chk("req_info", dcache_req_info_miss, er);
          last_req = er;
          if (!er[LW] && prev_store && m_wb < CMAX) m_wb++;
          prev_store = er[LW];
        end
      end else begin
        chk("req_hold", dcache_req_info_miss, last_req);
      end
      chk("wb_cnt", wb_cnt, m_wb);
      chk("miss_cnt", miss_cnt, m_miss);
      if (fill_valid) begin
        if (exp_fill_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fill_unexpected: got %h want no fill", {fill_addr, fill_data});
        end else begin
          ef = exp_fill_q.pop_front();
          chk("fill", {fill_addr, fill_data}, ef);
          last_fill = ef;
          if (m_miss < CMAX) m_miss++;
        end
      end else begin
        chk("fill_hold", {fill_addr, fill_data}, last_fill);
      end
    end
  end

  task automatic rsp(input bit id, input logic [LW-1:0] d);
    rsp_valid_miss = 1'b1; rsp_cache_id = id; rsp_data_miss = d;
    @(negedge clock);
    rsp_valid_miss = 1'b0; rsp_cache_id = 1'b0; rsp_data_miss = '0;
  endtask

  task automatic idle_busy(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("busy_ready", miss_ready, 1'b0);
    end
  endtask

  // Runs one miss from request to R+2; starts and ends on a negedge.
  task automatic do_miss(input logic [AW-1:0] a, input bit dirty, input logic [AW-1:0] ea,
                         input logic [LW-1:0] ed, input logic [LW-1:0] fd, input int dly,
                         input bit foreign, input bit hold);
    int n;
    if (dirty) exp_req_q.push_back({ea, 1'b1, ed});
    exp_req_q.push_back({a, 1'b0, {LW{1'b0}}});
    exp_fill_q.push_back({a, fd});
    miss_valid = 1'b1; miss_addr = a; evict_dirty = dirty; evict_addr = ea; evict_data = ed;
    n = 0;
    while (!miss_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("accept_ready", miss_ready, 1'b1);
    @(negedge clock);
    if (hold) begin
      miss_addr = nxt_addr; evict_dirty = nxt_dirty; evict_addr = nxt_eaddr; evict_data = nxt_edata;
    end else begin
      miss_valid = 1'b0; miss_addr = '1; evict_dirty = 1'b0; evict_addr = '1; evict_data = '1;
    end
    chk("req_at_t1", dcache_req_valid_miss, 1'b1);
    chk("busy_ready_t1", miss_ready, 1'b0);
    if (dirty) begin
      idle_busy(dly);
      rsp(1'b1, {LW{1'b1}});
      chk("load_after_wb", dcache_req_valid_miss, 1'b1);
      chk("busy_ready_wb", miss_ready, 1'b0);
    end
    idle_busy(dly);
    if (foreign) begin
      rsp(1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
      chk("no_fill_on_icache", fill_valid, 1'b0);
      chk("busy_ready_ic", miss_ready, 1'b0);
    end
    rsp(1'b1, fd);
    chk("fill_at_r1", fill_valid, 1'b1);
    chk("fill_data_r1", fill_data, fd);
    chk("ready_low_r1", miss_ready, 1'b0);
    @(negedge clock);
    chk("ready_at_r2", miss_ready, 1'b1);
    chk("fill_off_r2", fill_valid, 1'b0);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", miss_ready, 1'b1);
    chk("rst_req_valid", dcache_req_valid_miss, 1'b0);
    chk("rst_req_info", dcache_req_info_miss, 97'h0);
    chk("rst_fill_valid", fill_valid, 1'b0);
    chk("rst_fill", {fill_addr, fill_data}, 96'h0);
    chk("rst_cnts", {miss_cnt, wb_cnt}, 4'h0);

    // clean miss
    do_miss(32'h40, 1'b0, 32'h0, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 4, 1'b0, 1'b0);
    chk("clean_fill_addr", fill_addr, 32'h40);
    chk("clean_miss_cnt", miss_cnt, 2'd1);
    chk("clean_wb_cnt", wb_cnt, 2'd0);

    // dirty miss: writeback strictly before the load
    do_miss(32'h80, 1'b1, 32'h100, 64'h1234, 64'h5555_6666_7777_8888, 3, 1'b0, 1'b0);
    chk("dirty_wb_cnt", wb_cnt, 2'd1);
    chk("dirty_miss_cnt", miss_cnt, 2'd2);

    // I$ response in FILL_WAIT ignored
    do_miss(32'hC0, 1'b0, 32'h0, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 2, 1'b1, 1'b0);
    chk("foreign_fill_data", fill_data, 64'h0F0F_0F0F_0F0F_0F0F);
    chk("foreign_miss_cnt", miss_cnt, 2'd3);

    // back-pressure: second miss held, accepted at R+2
    nxt_addr = 32'h240; nxt_dirty = 1'b1; nxt_eaddr = 32'h300; nxt_edata = 64'hBEEF;
    do_miss(32'h200, 1'b0, 32'h0, 64'h0, 64'h1111_2222_3333_4444, 2, 1'b0, 1'b1);
    chk("bp_miss_valid_held", miss_valid, 1'b1);
    do_miss(32'h240, 1'b1, 32'h300, 64'hBEEF, 64'h9999_AAAA_BBBB_CCCC, 1, 1'b0, 1'b0);
    chk("bp_miss_cnt_sat", miss_cnt, 2'd3);
    chk("bp_wb_cnt", wb_cnt, 2'd2);

    // reset in WB_WAIT
    exp_req_q.push_back({32'h500, 1'b1, 64'h77});
    miss_valid = 1'b1; miss_addr = 32'h540; evict_dirty = 1'b1; evict_addr = 32'h500; evict_data = 64'h77;
    @(negedge clock);
    miss_valid = 1'b0;
    chk("rwb_req", dcache_req_valid_miss, 1'b1);
    @(negedge clock);
    chk("rwb_waiting", miss_ready, 1'b0);
    reset = 1'b1;
    exp_req_q.delete();
    exp_fill_q.delete();
    @(negedge clock);
    reset = 1'b0;
    chk("rwb_ready", miss_ready, 1'b1);
    chk("rwb_info", dcache_req_info_miss, 97'h0);
    chk("rwb_cnts", {miss_cnt, wb_cnt}, 4'h0);
    rsp(1'b1, 64'h1357_9BDF_1357_9BDF);
    for (int i = 0; i < 5; i++) begin
      chk("late_rsp_ready", miss_ready, 1'b1);
      chk("late_rsp_nofill", fill_valid, 1'b0);
      chk("late_rsp_cnts", {miss_cnt, wb_cnt}, 4'h0);
      @(negedge clock);
    end

    // saturation over five clean misses
    for (int i = 0; i < 5; i++) begin
      do_miss(32'h1000 + 32'(i) * 32'h40, 1'b0, 32'h0, 64'h0, {32'hCAFE_0000 + 32'(i), 32'h600D_F00D},
              1 + i, 1'b0, 1'b0);
      chk("sat_miss_cnt", miss_cnt, (i + 1 > CMAX) ? CMAX : i + 1);
    end
    chk("sat_final_miss", miss_cnt, 2'd3);
    chk("sat_final_wb", wb_cnt, 2'd0);

    repeat (2) @(negedge clock);
    chk("exp_req_drained", exp_req_q.size(), 0);
    chk("exp_fill_drained", exp_fill_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dcache_miss_unit.md
DCACHE_MISS_UNIT -- requirements
Module: dcache_miss_unit

Interface
REQ-001 Parameter LINE_W, default `DCACHE_LINE_WIDTH, cache line width in bits.
REQ-002 Parameter ADDR_W, default 32, line address width in bits.
REQ-003 Parameter CNT_W, default 16, statistics counter width in bits.
REQ-004 Port clock, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, synchronous, active-high reset.
REQ-006 Port miss_valid, input, 1, the D$ requests a line fill.
REQ-007 Port miss_addr, input, ADDR_W, line address to fill.
REQ-008 Port evict_dirty, input, 1, the victim line is dirty; sampled with miss_valid.
REQ-009 Port evict_addr, input, ADDR_W, victim line address.
REQ-010 Port evict_data, input, LINE_W, victim line data.
REQ-011 Port miss_ready, output, 1, the unit is idle and accepts a miss this cycle.
REQ-012 Port dcache_req_valid_miss, output, 1, one-cycle request pulse to the memory hierarchy.
REQ-013 Port dcache_req_info_miss, output, memory_request_t, request fields addr, is_store and data.
REQ-014 Port rsp_valid_miss, input, 1, response pulse from the memory hierarchy.
REQ-015 Port rsp_cache_id, input, 1, response target: 0 = I$, 1 = D$.
REQ-016 Port rsp_data_miss, input, LINE_W, response line data.
REQ-017 Port fill_valid, output, 1, one-cycle pulse delivering a fill line to the D$.
REQ-018 Port fill_addr, output, ADDR_W, address of the fill line.
REQ-019 Port fill_data, output, LINE_W, data of the fill line.
REQ-020 Port miss_cnt / wb_cnt, output, CNT_W each, counts of completed fills and completed writebacks.

Function
REQ-021 The FSM SHALL have the states IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT and DONE.
REQ-022 miss_ready SHALL be 1 only in IDLE; a miss is accepted when miss_valid & miss_ready, and the unit latches miss_addr, evict_dirty, evict_addr and evict_data in that cycle.
REQ-023 On acceptance, the FSM SHALL go to WB_REQ if evict_dirty=1, and otherwise to FILL_REQ.
REQ-024 In WB_REQ, dcache_req_valid_miss SHALL be 1 for exactly one cycle with is_store=1, addr=evict_addr and data=evict_data, and the FSM SHALL then go to WB_WAIT.
REQ-025 In FILL_REQ, dcache_req_valid_miss SHALL be 1 for exactly one cycle with is_store=0, addr=miss_addr and data=0, and the FSM SHALL then go to FILL_WAIT.
REQ-026 dcache_req_info_miss SHALL be registered, and it SHALL hold its last value while dcache_req_valid_miss=0.
REQ-027 The first request SHALL be issued on the cycle after acceptance, so the first dcache_req_valid_miss occurs at T+1 for an accept at T.
REQ-028 Only one request SHALL be outstanding at a time; no new request is issued until the D$ response for the previous one arrives.
REQ-029 A response SHALL count only when rsp_valid_miss=1 & rsp_cache_id=1; a response with rsp_cache_id=0 SHALL be ignored in every state.
REQ-030 In WB_WAIT, a D$ response SHALL increment wb_cnt, discard rsp_data_miss and move the FSM to FILL_REQ.
REQ-031 In FILL_WAIT, a D$ response SHALL capture rsp_data_miss and move the FSM to DONE.
REQ-032 In DONE, fill_valid SHALL be 1 for exactly one cycle with fill_addr=miss_addr and fill_data=the captured data, miss_cnt SHALL increment, and the FSM SHALL return to IDLE.
REQ-033 End-to-end latency SHALL be: a response at cycle R gives fill_valid at R+1, and miss_ready=1 at R+2.
REQ-034 A D$ response in IDLE, WB_REQ, FILL_REQ or DONE is a protocol error: it SHALL be ignored and SHALL cause no state change.
REQ-035 miss_cnt and wb_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-036 miss_valid while miss_ready=0 SHALL be ignored; the D$ holds the request until it is accepted.
REQ-037 fill_addr and fill_data SHALL hold their last values while fill_valid=0.

Reset
REQ-038 While reset=1, the FSM SHALL go to IDLE, and dcache_req_valid_miss, fill_valid, miss_cnt and wb_cnt SHALL be 0, dcache_req_info_miss, fill_addr and fill_data SHALL be 0, and miss_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-039 Reset asserted mid-operation SHALL abandon the transaction, and no fill_valid SHALL be produced for it.
REQ-040 A D$ response arriving after reset deasserts, for a request issued before reset, SHALL be ignored per REQ-034.

Verification
REQ-041 Clean miss:
- Stimulus: miss_addr=0x40, evict_dirty=0; response after 5 cycles with rsp_data_miss=0xA5...A5.
- Required: one request with is_store=0, addr=0x40; fill_valid one cycle later with fill_data=0xA5...A5; miss_cnt=1; wb_cnt=0.
REQ-042 Dirty miss:
- Stimulus: miss_addr=0x80, evict_addr=0x100, evict_data=0x1234; both responses returned.
- Required: store request (addr=0x100, data=0x1234) issued first; load request (addr=0x80) issued only after the store response; wb_cnt=1; miss_cnt=1.
REQ-043 Foreign response:
- Stimulus: rsp_cache_id=0 pulse during FILL_WAIT, followed by a rsp_cache_id=1 pulse.
- Required: no fill_valid on the I$ pulse; fill only on the D$ pulse, carrying the D$ data.
REQ-044 Back-pressure:
- Stimulus: miss_valid held high during an active miss.
- Required: miss_ready=0 throughout; the second miss is accepted exactly at R+2.
REQ-045 Reset in WB_WAIT:
- Stimulus: reset for 1 cycle during WB_WAIT; a late response arrives afterwards.
- Required: all outputs reset per REQ-038; the late response is ignored; no fill_valid; counters remain 0.
REQ-046 Saturation:
- Stimulus: CNT_W=2, five clean misses.
- Required: miss_cnt stops at 3.
